// File: rtl/crypto_seq_pkg.sv
// Shared types and defaults for the X25519 top-level sequencer.
package crypto_seq_pkg;

    localparam int unsigned DefFieldW     = 255;
    localparam int unsigned DefKeyW       = 256;
    localparam int unsigned DefTimeoutCyc = 4096;
    localparam int unsigned DefToW        = 13;

    // Latched run mode.
    localparam logic ModeProj   = 1'b0;
    localparam logic ModeAffine = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StKey,
        StLadder,
        StInv,
        StMul,
        StMod,
        StOut,
        StErr
    } state_e;

    // True for states that wait on an engine and are covered by the watchdog.
    function automatic logic is_stage(input state_e s);
        return (s == StKey) || (s == StLadder) || (s == StInv) ||
               (s == StMul) || (s == StMod);
    endfunction

endpackage

// File: rtl/crypto_seq_watchdog.sv
// Per-stage watchdog: cleared on every state entry, counts while a stage waits,
// flags a timeout once the count reaches TIMEOUT_CYC-1.
module crypto_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned TO_W        = 13
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    logic [TO_W-1:0] cnt_q, cnt_d;

    assign timeout_o = en_i && (cnt_q == TO_W'(TIMEOUT_CYC - 1));

    // Next count: clear wins, then count up until the timeout value is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !timeout_o) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/crypto_seq_top.sv
// X25519 top-level sequencer: key gen -> ladder -> (inverse -> multiply -> modulo)
// with per-stage watchdog, point-at-infinity check and valid/ready result port.
// Optional macro CRYPTO_SEQ_CYCLE_CNT_EN adds the crypto_cycle_count output.
module crypto_seq_top
    import crypto_seq_pkg::*;
#(
    parameter int unsigned FIELD_W     = DefFieldW,
    parameter int unsigned KEY_W       = DefKeyW,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
    parameter int unsigned TO_W        = DefToW
) (
    input  logic                        crypto_clk,
    input  logic                        crypto_reset_n,
    input  logic                        top_ready,
    input  logic                        mode_affine,
    output logic                        busy,
    output logic                        key_start,
    input  logic                        key_valid,
    input  logic [KEY_W-1:0]            key_data,
    output logic                        mont_start,
    output logic [KEY_W-1:0]            mont_scalar,
    input  logic                        mont_valid,
    input  logic [FIELD_W-1:0]          mont_rx,
    input  logic [FIELD_W-1:0]          mont_rz,
    output logic                        inv_start,
    output logic [FIELD_W-1:0]          inv_in,
    input  logic                        inv_valid,
    input  logic [FIELD_W-1:0]          inv_data,
    output logic                        mul_start,
    output logic [FIELD_W:0]            mul_a,
    output logic [FIELD_W:0]            mul_b,
    input  logic                        mul_done,
    input  logic [2*(FIELD_W+1)-1:0]    mul_out,
    output logic                        mod_start,
    output logic [2*(FIELD_W+1)-1:0]    mod_in,
    input  logic                        mod_done,
    input  logic [FIELD_W-1:0]          mod_result,
    output logic [FIELD_W-1:0]          crypto_data_out,
    output logic                        crypto_data_valid,
    input  logic                        crypto_data_ready,
    output logic                        crypto_error
`ifdef CRYPTO_SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0]                 crypto_cycle_count
`endif
);

    state_e state_q, state_d;
    logic   mode_q, mode_d;
    logic   timeout, wd_clr, wd_en;
    logic   key_hit, mont_hit, inv_hit, mul_hit, mod_hit;

    // Engine dones only count in their own state and never in the start cycle.
    always_comb begin
        key_hit  = (state_q == StKey)    && key_valid  && !key_start;
        mont_hit = (state_q == StLadder) && mont_valid && !mont_start;
        inv_hit  = (state_q == StInv)    && inv_valid  && !inv_start;
        mul_hit  = (state_q == StMul)    && mul_done   && !mul_start;
        mod_hit  = (state_q == StMod)    && mod_done   && !mod_start;
    end

    // Next-state logic; an engine done in the timeout cycle takes priority.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (top_ready) begin
                    state_d = StKey;
                    mode_d  = mode_affine;
                end
            end
            StKey:    if (key_hit) state_d = StLadder; else if (timeout) state_d = StErr;
            StLadder: begin
                if (mont_hit) begin
                    if (mode_q == ModeProj)     state_d = StOut;
                    else if (mont_rz == '0)     state_d = StErr;
                    else                        state_d = StInv;
                end else if (timeout) begin
                    state_d = StErr;
                end
            end
            StInv:    if (inv_hit) state_d = StMul; else if (timeout) state_d = StErr;
            StMul:    if (mul_hit) state_d = StMod; else if (timeout) state_d = StErr;
            StMod:    if (mod_hit) state_d = StOut; else if (timeout) state_d = StErr;
            StOut, StErr: if (crypto_data_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign wd_clr = (state_d != state_q);
    assign wd_en  = is_stage(state_q);

    crypto_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_watchdog (
        .clk_i     (crypto_clk),
        .rst_ni    (crypto_reset_n),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .timeout_o (timeout)
    );

    // State, mode and all registered outputs, derived from the next state.
    always_ff @(posedge crypto_clk or negedge crypto_reset_n) begin
        if (!crypto_reset_n) begin
            state_q           <= StIdle;
            mode_q            <= ModeProj;
            busy              <= 1'b0;
            key_start         <= 1'b0;
            mont_start        <= 1'b0;
            inv_start         <= 1'b0;
            mul_start         <= 1'b0;
            mod_start         <= 1'b0;
            mont_scalar       <= '0;
            inv_in            <= '0;
            mul_a             <= '0;
            mul_b             <= '0;
            mod_in            <= '0;
            crypto_data_out   <= '0;
            crypto_data_valid <= 1'b0;
            crypto_error      <= 1'b0;
        end else begin
            state_q           <= state_d;
            mode_q            <= mode_d;
            busy              <= (state_d != StIdle);
            key_start         <= (state_d == StKey)    && (state_q != StKey);
            mont_start        <= (state_d == StLadder) && (state_q != StLadder);
            inv_start         <= (state_d == StInv)    && (state_q != StInv);
            mul_start         <= (state_d == StMul)    && (state_q != StMul);
            mod_start         <= (state_d == StMod)    && (state_q != StMod);
            crypto_data_valid <= (state_d == StOut) || (state_d == StErr);
            crypto_error      <= (state_d == StErr);
            if (key_hit) mont_scalar <= key_data;
            if (mont_hit) begin
                mul_a  <= {1'b0, mont_rx};
                inv_in <= mont_rz;
            end
            if (inv_hit) mul_b  <= {1'b0, inv_data};
            if (mul_hit) mod_in <= mul_out;
            if ((state_d == StErr) && (state_q != StErr)) begin
                crypto_data_out <= '0;
            end else if (mont_hit && (mode_q == ModeProj)) begin
                crypto_data_out <= mont_rx;
            end else if (mod_hit) begin
                crypto_data_out <= mod_result;
            end
        end
    end

`ifdef CRYPTO_SEQ_CYCLE_CNT_EN
    logic [31:0] cyc_q;
    assign crypto_cycle_count = cyc_q;

    // Run length: restart on leaving IDLE, count stage cycles, saturate, hold otherwise.
    always_ff @(posedge crypto_clk or negedge crypto_reset_n) begin
        if (!crypto_reset_n) begin
            cyc_q <= '0;
        end else if ((state_q == StIdle) && (state_d == StKey)) begin
            cyc_q <= '0;
        end else if (is_stage(state_q) && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crypto_seq_top.sv
// Directed scoreboard bench for crypto_seq_top (TIMEOUT_CYC=16).
module tb_crypto_seq_top;

    localparam int unsigned FW = 255;
    localparam int unsigned KW = 256;
    localparam int unsigned PW = 2 * (FW + 1);

    typedef logic [511:0] w_t;
    typedef struct {
        logic [FW-1:0] data;
        logic          err;
    } exp_t;

    logic          crypto_clk = 1'b0;
    logic          crypto_reset_n;
    logic          top_ready, mode_affine, busy;
    logic          key_start, key_valid;
    logic [KW-1:0] key_data, mont_scalar;
    logic          mont_start, mont_valid;
    logic [FW-1:0] mont_rx, mont_rz, inv_in, inv_data, mod_result, crypto_data_out;
    logic          inv_start, inv_valid, mul_start, mul_done, mod_start, mod_done;
    logic [FW:0]   mul_a, mul_b;
    logic [PW-1:0] mul_out, mod_in;
    logic          crypto_data_valid, crypto_data_ready, crypto_error;
`ifdef CRYPTO_SEQ_CYCLE_CNT_EN
    logic [31:0]   crypto_cycle_count;
`endif

    exp_t sb_q[$];
    int   start_log[$];
    int   n_inv = 0;
    int   n_mod = 0;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 crypto_clk = ~crypto_clk;

    crypto_seq_top #(
        .FIELD_W     (FW),
        .KEY_W       (KW),
        .TIMEOUT_CYC (16),
        .TO_W        (5)
    ) dut (
        .crypto_clk        (crypto_clk),
        .crypto_reset_n    (crypto_reset_n),
        .top_ready         (top_ready),
        .mode_affine       (mode_affine),
        .busy              (busy),
        .key_start         (key_start),
        .key_valid         (key_valid),
        .key_data          (key_data),
        .mont_start        (mont_start),
        .mont_scalar       (mont_scalar),
        .mont_valid        (mont_valid),
        .mont_rx           (mont_rx),
        .mont_rz           (mont_rz),
        .inv_start         (inv_start),
        .inv_in            (inv_in),
        .inv_valid         (inv_valid),
        .inv_data          (inv_data),
        .mul_start         (mul_start),
        .mul_a             (mul_a),
        .mul_b             (mul_b),
        .mul_done          (mul_done),
        .mul_out           (mul_out),
        .mod_start         (mod_start),
        .mod_in            (mod_in),
        .mod_done          (mod_done),
        .mod_result        (mod_result),
        .crypto_data_out   (crypto_data_out),
        .crypto_data_valid (crypto_data_valid),
        .crypto_data_ready (crypto_data_ready),
        .crypto_error      (crypto_error)
`ifdef CRYPTO_SEQ_CYCLE_CNT_EN
        ,
        .crypto_cycle_count (crypto_cycle_count)
`endif
    );

    // Log every start pulse in the order the DUT issues them.
    always @(posedge crypto_clk) begin
        if (key_start)  start_log.push_back(0);
        if (mont_start) start_log.push_back(1);
        if (inv_start)  begin start_log.push_back(2); n_inv <= n_inv + 1; end
        if (mul_start)  start_log.push_back(3);
        if (mod_start)  begin start_log.push_back(4); n_mod <= n_mod + 1; end
    end

    task automatic check(input string tag, input w_t obs, input w_t exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge crypto_clk);
        #1;
    endtask

    function automatic logic start_of(input int which);
        case (which)
            0:       return key_start;
            1:       return mont_start;
            2:       return inv_start;
            3:       return mul_start;
            4:       return mod_start;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_done(input int which, input logic v);
        case (which)
            0:       key_valid  = v;
            1:       mont_valid = v;
            2:       inv_valid  = v;
            3:       mul_done   = v;
            default: mod_done   = v;
        endcase
    endtask

    task automatic wait_start(input int which);
        int n = 0;
        while (!start_of(which) && n < 64) begin
            tick();
            n++;
        end
        check($sformatf("start_seen_%0d", which), w_t'(start_of(which)), w_t'(1));
    endtask

    // Wait for the start pulse, then answer one cycle later (start cycle is ignored).
    task automatic run_stage(input int which);
        wait_start(which);
        tick();
        set_done(which, 1'b1);
        tick();
        set_done(which, 1'b0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!crypto_data_valid && n < 64) begin
            tick();
            n++;
        end
        check(tag, w_t'(crypto_data_valid), w_t'(1));
    endtask

    task automatic sb_compare(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, w_t'(sb_q.size() != 0), w_t'(1));
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_data"}, w_t'(crypto_data_out), w_t'(e.data));
            check({tag, "_err"}, w_t'(crypto_error), w_t'(e.err));
        end
    endtask

    task automatic accept(input string tag);
        crypto_data_ready = 1'b1;
        tick();
        crypto_data_ready = 1'b0;
        check({tag, "_valid_drop"}, w_t'(crypto_data_valid), w_t'(0));
    endtask

    // Request a run; flip mode afterwards to show it is latched.
    task automatic begin_run(input logic mode);
        mode_affine = mode;
        top_ready   = 1'b1;
        tick();
        top_ready   = 1'b0;
        mode_affine = ~mode;
    endtask

    initial begin
        int base_inv;
        int base_mod;
        int base_log;
        crypto_reset_n    = 1'b0;
        top_ready         = 1'b0;
        mode_affine       = 1'b0;
        key_valid         = 1'b0;
        key_data          = '0;
        mont_valid        = 1'b0;
        mont_rx           = '0;
        mont_rz           = '0;
        inv_valid         = 1'b0;
        inv_data          = '0;
        mul_done          = 1'b0;
        mul_out           = '0;
        mod_done          = 1'b0;
        mod_result        = '0;
        crypto_data_ready = 1'b0;
        #12;
        check("rst_busy", w_t'(busy), w_t'(0));
        check("rst_key_start", w_t'(key_start), w_t'(0));
        check("rst_valid", w_t'(crypto_data_valid), w_t'(0));
        check("rst_error", w_t'(crypto_error), w_t'(0));
        check("rst_data", w_t'(crypto_data_out), w_t'(0));
        check("rst_scalar", w_t'(mont_scalar), w_t'(0));
        @(negedge crypto_clk);
        crypto_reset_n = 1'b1;
        tick();
        check("idle_busy", w_t'(busy), w_t'(0));

        // Projective run; key_valid in the start cycle must be ignored.
        base_inv = n_inv;
        mont_rx  = FW'('h1234);
        mont_rz  = FW'(5);
        begin_run(1'b0);
        check("proj_key_start", w_t'(key_start), w_t'(1));
        check("proj_busy", w_t'(busy), w_t'(1));
        key_valid = 1'b1;
        key_data  = KW'('hFF);
        tick();
        key_data  = KW'('h09);
        tick();
        key_valid = 1'b0;
        check("proj_mont_start", w_t'(mont_start), w_t'(1));
        check("proj_scalar", w_t'(mont_scalar), w_t'('h09));
        sb_q.push_back('{data: FW'('h1234), err: 1'b0});
        tick();
        mont_valid = 1'b1;
        tick();
        mont_valid = 1'b0;
        check("proj_latency", w_t'(crypto_data_valid), w_t'(1));
        sb_compare("proj");
        check("proj_no_inv", w_t'(n_inv - base_inv), w_t'(0));
        accept("proj");
        check("proj_idle", w_t'(busy), w_t'(0));

        // Affine run: all five stages, in order, once each.
        mont_rz    = FW'(3);
        inv_data   = FW'('hAB);
        mul_out    = PW'('h55);
        mod_result = FW'('h77);
        tick();
        base_log = start_log.size();
        begin_run(1'b1);
        sb_q.push_back('{data: FW'('h77), err: 1'b0});
        for (int s = 0; s < 5; s++) run_stage(s);
        wait_valid("aff_valid");
        sb_compare("aff");
        check("aff_starts", w_t'(start_log.size() - base_log), w_t'(5));
        for (int s = 0; s < 5; s++) begin
            if (base_log + s < start_log.size())
                check($sformatf("aff_order_%0d", s), w_t'(start_log[base_log + s]), w_t'(s));
        end
        check("aff_inv_in", w_t'(inv_in), w_t'(3));
        check("aff_mul_a", w_t'(mul_a), w_t'('h1234));
        check("aff_mul_b", w_t'(mul_b), w_t'('hAB));
        check("aff_mod_in", w_t'(mod_in), w_t'('h55));
        accept("aff");

        // Point at infinity.
        mont_rz  = '0;
        base_inv = n_inv;
        tick();
        begin_run(1'b1);
        sb_q.push_back('{data: '0, err: 1'b1});
        run_stage(0);
        run_stage(1);
        wait_valid("inf_valid");
        sb_compare("inf");
        tick();
        check("inf_no_inv", w_t'(n_inv - base_inv), w_t'(0));
        check("inf_hold", w_t'(crypto_data_valid), w_t'(1));
        accept("inf");

        // Inverse never answers: ERR exactly 16 cycles after INV entry.
        mont_rz = FW'(3);
        tick();
        begin_run(1'b1);
        sb_q.push_back('{data: '0, err: 1'b1});
        run_stage(0);
        run_stage(1);
        wait_start(2);
        repeat (15) tick();
        check("to_not_yet", w_t'(crypto_data_valid), w_t'(0));
        tick();
        check("to_valid", w_t'(crypto_data_valid), w_t'(1));
        sb_compare("to");
        accept("to");

        // Done on the timeout cycle wins.
        tick();
        begin_run(1'b1);
        sb_q.push_back('{data: FW'('h77), err: 1'b0});
        run_stage(0);
        run_stage(1);
        wait_start(2);
        repeat (15) tick();
        inv_valid = 1'b1;
        tick();
        inv_valid = 1'b0;
        check("late_mul_start", w_t'(mul_start), w_t'(1));
        check("late_no_err", w_t'(crypto_data_valid), w_t'(0));
        run_stage(3);
        run_stage(4);
        wait_valid("late_valid");
        sb_compare("late");
        accept("late");

        // Backpressure, then back-to-back restart with top_ready held.
        mont_rz = FW'(5);
        tick();
        begin_run(1'b0);
        sb_q.push_back('{data: FW'('h1234), err: 1'b0});
        run_stage(0);
        run_stage(1);
        wait_valid("bp_valid");
        sb_compare("bp");
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp_valid_%0d", i), w_t'(crypto_data_valid), w_t'(1));
            check($sformatf("bp_data_%0d", i), w_t'(crypto_data_out), w_t'('h1234));
        end
        top_ready         = 1'b1;
        crypto_data_ready = 1'b1;
        tick();
        crypto_data_ready = 1'b0;
        check("bp_drop", w_t'(crypto_data_valid), w_t'(0));
        check("bp_idle_nostart", w_t'(key_start), w_t'(0));
        tick();
        check("bp_restart", w_t'(key_start), w_t'(1));
        top_ready = 1'b0;

        // The restarted run latched mode=1; reset it during MUL.
        mont_rz = FW'(3);
        run_stage(0);
        run_stage(1);
        run_stage(2);
        wait_start(3);
        tick();
        #2;
        crypto_reset_n = 1'b0;
        #1;
        check("ar_busy", w_t'(busy), w_t'(0));
        check("ar_mul_a", w_t'(mul_a), w_t'(0));
        check("ar_scalar", w_t'(mont_scalar), w_t'(0));
        check("ar_inv_in", w_t'(inv_in), w_t'(0));
        check("ar_data", w_t'(crypto_data_out), w_t'(0));
        mul_done = 1'b1;
        tick();
        crypto_reset_n = 1'b1;
        base_mod = n_mod;
        tick();
        tick();
        check("ar_busy_after", w_t'(busy), w_t'(0));
        check("ar_no_mod", w_t'(n_mod - base_mod), w_t'(0));
        check("ar_mod_in", w_t'(mod_in), w_t'(0));
        check("ar_valid", w_t'(crypto_data_valid), w_t'(0));
        mul_done = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
